// File: rtl/fir_tap_sequencer.sv
// Control scheduler for a time-multiplexed FIR: one shared MAC sequenced over TAPS coefficients.
// Define FIR_SEQ_PEND_EN to hold one pending sample edge and chain runs without an idle cycle.
module fir_tap_sequencer #(
    parameter int unsigned TAPS     = 16,
    parameter int unsigned ADDR_W   = $clog2(TAPS),
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              sample_clk,
    input  logic              run_en,
    input  logic              ovr_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] x_addr,
    output logic [ADDR_W-1:0] c_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_last,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);
    typedef enum logic [2:0] {StIdle, StLoad, StMac, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastTap   = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W:0]   TapsW     = (ADDR_W + 1)'(TAPS);
    localparam logic [2:0]        DrainLast = 3'(PIPE_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [2:0]        drn_q, drn_d;
    logic              sclk_q;
    logic              ovr_q, ovr_d;

    logic              accept;
    logic              busy_s;
    logic              chain;
    logic              ovr_set;
    logic [ADDR_W-1:0] head_m1;
    logic [ADDR_W:0]   x_sum;

    assign accept  = sample_clk & ~sclk_q & run_en;
    assign busy_s  = (state_q != StIdle);
    assign head_m1 = (head_q == '0) ? LastTap : head_q - 1'b1;
    assign x_sum   = {1'b0, head_q} + {1'b0, tap_q};

`ifdef FIR_SEQ_PEND_EN
    logic pend_q, pend_d;

    // A second edge while one is already pending is the only overrun case.
    always_comb begin
        ovr_set = accept & busy_s & pend_q;
        chain   = pend_q | (accept & busy_s);
        pend_d  = pend_q;
        if (state_q == StDone) begin
            pend_d = 1'b0;
        end else if (accept && busy_s) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    always_comb begin
        ovr_set = accept & busy_s;
        chain   = 1'b0;
    end
`endif

    assign ovr_d = ovr_set | (ovr_q & ~ovr_clr);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= StIdle;
            head_q  <= '0;
            tap_q   <= '0;
            drn_q   <= '0;
            sclk_q  <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tap_q   <= tap_d;
            drn_q   <= drn_d;
            sclk_q  <= sample_clk;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tap_d   = tap_q;
        drn_d   = drn_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StLoad;
            end
            StLoad: begin
                head_d  = head_m1;
                tap_d   = '0;
                state_d = StMac;
            end
            StMac: begin
                if (tap_q == LastTap) begin
                    drn_d   = '0;
                    state_d = (PIPE_LAT == 0) ? StDone : StDrain;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StDrain: begin
                if (drn_q == DrainLast) state_d = StDone;
                else                    drn_d   = drn_q + 1'b1;
            end
            StDone: begin
                state_d = chain ? StLoad : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Address outputs are plain functions of head/tap, so they hold once strobes drop.
    always_comb begin
        wr_en     = (state_q == StLoad);
        mac_clr   = (state_q == StLoad);
        mac_en    = (state_q == StMac);
        mac_last  = (state_q == StMac) && (tap_q == LastTap);
        out_valid = (state_q == StDone);
        busy      = busy_s;
        overrun   = ovr_q;
        wr_addr   = (state_q == StLoad) ? head_m1 : head_q;
        c_addr    = tap_q;
        x_addr    = (x_sum >= TapsW) ? ADDR_W'(x_sum - TapsW) : ADDR_W'(x_sum);
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: two configurations (16/2 and 5/0) share random stimulus and are
// scored against a timeline reference model of accepted sample edges.
module tb_fir_tap_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, sample_clk, run_en, ovr_clr;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ld;
        int wr;
    } run_t;

    task automatic check(input string name, input int inst, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%0h expected=%0h", name, inst, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int T  = (g == 0) ? 16 : 5;
        localparam int PL = (g == 0) ? 2 : 0;
        localparam int AW = $clog2(T);

        logic          wr_en, mac_clr, mac_en, mac_last, out_valid, busy, overrun;
        logic [AW-1:0] wr_addr, x_addr, c_addr;

        fir_tap_sequencer #(
            .TAPS    (T),
            .ADDR_W  (AW),
            .PIPE_LAT(PL)
        ) u_dut (
            .clk_in    (clk),
            .rst_n     (rst_n),
            .sample_clk(sample_clk),
            .run_en    (run_en),
            .ovr_clr   (ovr_clr),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .x_addr    (x_addr),
            .c_addr    (c_addr),
            .mac_clr   (mac_clr),
            .mac_en    (mac_en),
            .mac_last  (mac_last),
            .out_valid (out_valid),
            .busy      (busy),
            .overrun   (overrun)
        );

        run_t q[$];
        bit   ovr_tab[4];
        int   m_head = 0;
        int   m_done = 0;
        bit   m_prev = 1'b1;
        bit   m_pend = 1'b0;
        int   runs_seen = 0;
        run_t cur;
        bit   act = 1'b0;

        // A run loaded in cycle L is busy through L+T+PL+1 and writes the slot before the newest.
        task automatic start_run(input int ld);
            run_t r;
            m_head = (m_head + T - 1) % T;
            r.ld   = ld;
            r.wr   = m_head;
            q.push_back(r);
            m_done = ld + T + PL + 1;
        endtask

        // Reference model: decides, per cycle of stimulus, which edges start runs.
        always @(negedge clk) begin
            bit rise;
            bit set;
            bit nxt;
            nxt = ovr_tab[cyc % 4];
            if (rst_n !== 1'b1) begin
                m_prev = 1'b1;
                m_head = 0;
                m_done = cyc;
                m_pend = 1'b0;
                nxt    = 1'b0;
            end else begin
                rise   = sample_clk && !m_prev;
                m_prev = sample_clk;
                set    = 1'b0;
                if (rise && run_en) begin
                    if (cyc > m_done) begin
                        start_run(cyc + 1);
                    end else begin
`ifdef FIR_SEQ_PEND_EN
                        if (m_pend) set = 1'b1;
                        else        m_pend = 1'b1;
`else
                        set = 1'b1;
`endif
                    end
                end
`ifdef FIR_SEQ_PEND_EN
                if (cyc == m_done && m_pend) begin
                    m_pend = 1'b0;
                    start_run(cyc + 1);
                end
`endif
                if (set)          nxt = 1'b1;
                else if (ovr_clr) nxt = 1'b0;
            end
            ovr_tab[(cyc + 1) % 4] = nxt;
        end

        // Monitor: picks up a run when the DUT loads (or should have), then scores every cycle.
        always @(negedge clk) begin
            int         t;
            int         last;
            bit         in_run;
            logic [6:0] e;
            if (mon_on) begin
                if ((wr_en === 1'b1 || (q.size() > 0 && q[0].ld == cyc)) && q.size() > 0) begin
                    cur = q.pop_front();
                    act = 1'b1;
                    check("load_cycle", g, cyc, cur.ld);
                    check("wr_addr", g, wr_addr, cur.wr);
                end
                last   = cur.ld + T + PL + 1;
                in_run = act && cyc >= cur.ld && cyc <= last;
                t      = cyc - cur.ld - 1;
                e[6]   = in_run && cyc == cur.ld;
                e[5]   = in_run && cyc == cur.ld;
                e[4]   = in_run && t >= 0 && t < T;
                e[3]   = in_run && t == T - 1;
                e[2]   = in_run && cyc == last;
                e[1]   = in_run;
                e[0]   = ovr_tab[cyc % 4];
                check("strobes", g, {wr_en, mac_clr, mac_en, mac_last, out_valid, busy, overrun}, e);
                if (e[4]) begin
                    check("c_addr", g, c_addr, t);
                    check("x_addr", g, x_addr, (cur.wr + t) % T);
                end
                if (e[2] && out_valid === 1'b1) runs_seen++;
                if (rst_n !== 1'b1 || e[2]) act = 1'b0;
            end
        end
    end

    task automatic step(input bit s, input bit r, input bit c, input bit rn);
        @(posedge clk);
        #1;
        sample_clk = s;
        run_en     = r;
        ovr_clr    = c;
        rst_n      = rn;
    endtask

    task automatic sample(input int period, input int lo, input bit r, input int clr_mod);
        for (int i = 0; i < period; i++) begin
            step(i >= lo, r, ($urandom % clr_mod) == 0, 1'b1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        sample_clk = 1'b1;
        run_en     = 1'b1;
        ovr_clr    = 1'b0;
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        mon_on = 1'b1;
        @(negedge clk);
        check("reset_addr", 0, {g_cfg[0].wr_addr, g_cfg[0].x_addr, g_cfg[0].c_addr}, 0);
        check("reset_addr", 1, {g_cfg[1].wr_addr, g_cfg[1].x_addr, g_cfg[1].c_addr}, 0);

        // sample_clk high across reset release must not be an edge
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1);

        // well-spaced samples, enough to wrap the delay line head
        for (int n = 0; n < 18; n++) sample($urandom_range(22, 34), $urandom_range(2, 10), 1'b1, 1000);

        // tighter spacing, random run_en and clears
        for (int n = 0; n < 10; n++) begin
            sample($urandom_range(6, 30), $urandom_range(1, 4), $urandom_range(0, 3) != 0, 8);
        end

        // second edge at E+5, then a clear coinciding with another busy edge
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (25) step(1'b1, 1'b1, 1'b0, 1'b1);

        // reset in the middle of a run, then a fresh sample
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        sample(30, 3, 1'b1, 1000);

        // edges with run_en low are ignored
        sample(30, 3, 1'b0, 1000);

        // per-cycle chaos including occasional resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), ($urandom % 4) != 0, ($urandom % 6) == 0,
                 ($urandom % 120) != 0);
        end

        repeat (40) step(1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("runs_completed", 0, g_cfg[0].runs_seen >= 15, 1);
        check("runs_completed", 1, g_cfg[1].runs_seen >= 15, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
